// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions used by the transmit mapper and the receive slicer.
package qpsk_pkg;

  localparam int unsigned QPSK_SAMPLE_W    = 19;
  localparam int unsigned QPSK_SPS_DEFAULT = 16;

  typedef logic signed [QPSK_SAMPLE_W-1:0] qpsk_sample_t;

  typedef enum logic {
    StIdle,
    StActive
  } qpsk_state_e;

  // bit 1 -> +amp, bit 0 -> -amp, so the receiver decision "sum > 0 -> 1" holds.
  function automatic qpsk_sample_t map_bit(input logic b, input qpsk_sample_t amp);
    return b ? amp : qpsk_sample_t'(-amp);
  endfunction

endpackage

// File: rtl/qpsk_bit_pair_buffer.sv
// Two-entry pending buffer pairing serial bits as (I first, Q second).
module qpsk_bit_pair_buffer (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic pop,
  output logic pair_ready,
  output logic pend_i,
  output logic pend_q
);

  logic [1:0] pend_cnt_q, pend_cnt_d;
  logic       pend_i_q, pend_i_d;
  logic       pend_q_q, pend_q_d;
  logic       accept;

  assign bit_ready  = (pend_cnt_q != 2'd2);
  assign pair_ready = (pend_cnt_q == 2'd2);
  assign accept     = bit_valid && bit_ready;
  assign pend_i     = pend_i_q;
  assign pend_q     = pend_q_q;

  // pop only occurs with a full pair, when accept is blocked, so the two never coincide.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    pend_i_d   = pend_i_q;
    pend_q_d   = pend_q_q;
    if (pop) begin
      pend_cnt_d = 2'd0;
    end else if (accept) begin
      if (pend_cnt_q == 2'd0) begin
        pend_i_d = bit_in;
      end else begin
        pend_q_d = bit_in;
      end
      pend_cnt_d = pend_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_q <= 2'd0;
      pend_i_q   <= 1'b0;
      pend_q_q   <= 1'b0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      pend_i_q   <= pend_i_d;
      pend_q_q   <= pend_q_d;
    end
  end

endmodule

// File: rtl/qpsk_symbol_modulator.sv
// Baseband QPSK mapper: pairs serial bits into I/Q symbols held for SPS clocks as NRZ samples.
module qpsk_symbol_modulator
  import qpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = QPSK_SAMPLE_W,
  parameter int unsigned SPS       = QPSK_SPS_DEFAULT,
  parameter int unsigned AMPLITUDE = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic signed [SAMPLE_W-1:0] I_sample,
  output logic signed [SAMPLE_W-1:0] Q_sample,
  output logic                       sample_valid,
  output logic                       sym_start,
  output logic                       underrun
);

  localparam int unsigned CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);
  localparam qpsk_sample_t AMP = qpsk_sample_t'(AMPLITUDE);

  qpsk_state_e               state_q, state_d;
  logic [CNT_W-1:0]          sample_cnt_q, sample_cnt_d;
  logic signed [SAMPLE_W-1:0] i_q, i_d;
  logic signed [SAMPLE_W-1:0] q_q, q_d;
  logic                      valid_q, valid_d;
  logic                      start_q, start_d;
  logic                      underrun_q, underrun_d;

  logic                      pop;
  logic                      pair_ready;
  logic                      pend_i;
  logic                      pend_q;
  logic                      sym_end;
  logic signed [SAMPLE_W-1:0] mapped_i;
  logic signed [SAMPLE_W-1:0] mapped_q;

  qpsk_bit_pair_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .pop        (pop),
    .pair_ready (pair_ready),
    .pend_i     (pend_i),
    .pend_q     (pend_q)
  );

  assign mapped_i = SAMPLE_W'(map_bit(pend_i, AMP));
  assign mapped_q = SAMPLE_W'(map_bit(pend_q, AMP));
  assign sym_end  = (state_q == StActive) && (sample_cnt_q == LAST_CNT);
  // A pair is loaded straight into the output registers, giving two clocks of latency.
  assign pop      = pair_ready && ((state_q == StIdle) || sym_end);

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    i_d          = i_q;
    q_d          = q_q;
    valid_d      = valid_q;
    start_d      = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      StIdle: begin
        i_d     = '0;
        q_d     = '0;
        valid_d = 1'b0;
      end
      StActive: begin
        if (sym_end) begin
          underrun_d   = 1'b1;
          i_d          = '0;
          q_d          = '0;
          valid_d      = 1'b0;
          sample_cnt_d = '0;
          state_d      = StIdle;
        end else begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      i_d          = mapped_i;
      q_d          = mapped_q;
      valid_d      = 1'b1;
      start_d      = 1'b1;
      underrun_d   = 1'b0;
      sample_cnt_d = '0;
      state_d      = StActive;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      i_q          <= '0;
      q_q          <= '0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      i_q          <= i_d;
      q_q          <= q_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      underrun_q   <= underrun_d;
    end
  end

  assign I_sample     = i_q;
  assign Q_sample     = q_q;
  assign sample_valid = valid_q;
  assign sym_start    = start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_qpsk_symbol_modulator.sv
// Directed bench: per-cycle vector table plus a handshake sequence under backpressure.
module tb_qpsk_symbol_modulator;

  localparam int P    = 100;
  localparam int N    = -100;
  localparam int MAXA = 262143;

  typedef struct {
    logic rst;
    logic chk;
    logic v;
    logic b;
    logic r;
    logic sv;
    logic ss;
    logic un;
    int   i;
    int   q;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic bit_valid;
  logic bit_ready, bit_ready_m;
  logic signed [18:0] i_s, q_s, i_m, q_m;
  logic sv, ss, un, sv_m, ss_m, un_m;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  qpsk_symbol_modulator #(
    .SAMPLE_W  (19),
    .SPS       (4),
    .AMPLITUDE (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .I_sample     (i_s),
    .Q_sample     (q_s),
    .sample_valid (sv),
    .sym_start    (ss),
    .underrun     (un)
  );

  qpsk_symbol_modulator #(
    .SAMPLE_W  (19),
    .SPS       (4),
    .AMPLITUDE (MAXA)
  ) dut_max (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready_m),
    .I_sample     (i_m),
    .Q_sample     (q_m),
    .sample_valid (sv_m),
    .sym_start    (ss_m),
    .underrun     (un_m)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r_rst, input logic r_chk, input logic r_v, input logic r_b,
                     input logic r_r, input logic r_sv, input logic r_ss, input logic r_un,
                     input int r_i, input int r_q);
    vec_t e;
    e.rst = r_rst; e.chk = r_chk; e.v = r_v; e.b = r_b; e.r = r_r;
    e.sv = r_sv; e.ss = r_ss; e.un = r_un; e.i = r_i; e.q = r_q;
    vecs.push_back(e);
  endtask

  function automatic int scale_max(input int e);
    return (e > 0) ? MAXA : ((e < 0) ? -MAXA : 0);
  endfunction

  task automatic build_vectors();
    // Bits 1,0 then underrun.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,1,0, 1,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 1,1,1,0,P,N);
    for (int k = 0; k < 3; k++) add(0,1,0,0, 1,1,0,0,P,N);
    add(0,1,0,0, 1,0,0,1,0,0);
    add(0,1,0,0, 1,0,0,0,0,0);
    // Continuous source: 11 00 01 10.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0,0);
    add(0,1,1,0, 1,1,1,0,P,P);
    add(0,1,1,0, 1,1,0,0,P,P);
    add(0,1,1,0, 0,1,0,0,P,P);
    add(0,1,1,0, 0,1,0,0,P,P);
    add(0,1,1,0, 1,1,1,0,N,N);
    add(0,1,1,1, 1,1,0,0,N,N);
    add(0,1,1,1, 0,1,0,0,N,N);
    add(0,1,1,1, 0,1,0,0,N,N);
    add(0,1,1,1, 1,1,1,0,N,P);
    add(0,1,1,0, 1,1,0,0,N,P);
    add(0,1,0,0, 0,1,0,0,N,P);
    add(0,1,0,0, 0,1,0,0,N,P);
    add(0,1,0,0, 1,1,1,0,P,N);
    for (int k = 0; k < 3; k++) add(0,1,0,0, 1,1,0,0,P,N);
    add(0,1,0,0, 1,0,0,1,0,0);
    // Lone bit during a symbol: underrun keeps it, next bit completes the pair.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0, 1,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 1,1,1,0,N,P);
    add(0,1,1,1, 1,1,0,0,N,P);
    add(0,1,0,0, 1,1,0,0,N,P);
    add(0,1,0,0, 1,1,0,0,N,P);
    add(0,1,0,0, 1,0,0,1,0,0);
    add(0,1,1,0, 1,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 1,1,1,0,P,N);
    // Reset at sample_cnt=2 with a full pending pair.
    add(1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0);
    add(0,1,1,0, 1,1,1,0,P,P);
    add(0,1,1,0, 1,1,0,0,P,P);
    add(1,1,0,0, 0,1,0,0,P,P);
    for (int k = 0; k < 4; k++) add(0,1,0,0, 1,0,0,0,0,0);
    add(0,1,1,0, 1,0,0,0,0,0);
    add(0,1,1,1, 1,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 1,1,1,0,N,P);
    add(0,1,0,0, 1,1,0,0,N,P);
  endtask

  initial begin
    int bits3[6];
    int exp_acc[6];
    int acc_cyc[6];
    int sym_cyc[4];
    int sym_i[4];
    int sym_q[4];
    int idx;
    int nsym;
    int first_under;
    int early_under;

    rst = 1'b1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    build_vectors();
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst;
      bit_valid = vecs[k].v;
      bit_in = vecs[k].b;
      @(negedge clk);
      if (vecs[k].chk) begin
        check($sformatf("row%0d flags{ready,valid,start,underrun}", k),
              int'({bit_ready, sv, ss, un}),
              int'({vecs[k].r, vecs[k].sv, vecs[k].ss, vecs[k].un}));
        check($sformatf("row%0d I", k), int'(i_s), vecs[k].i);
        check($sformatf("row%0d Q", k), int'(q_s), vecs[k].q);
        check($sformatf("row%0d I fullscale", k), int'(i_m), scale_max(vecs[k].i));
        check($sformatf("row%0d Q fullscale", k), int'(q_m), scale_max(vecs[k].q));
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: source always valid, 6 bits must come out as 3 symbols in order.
    bits3 = '{1, 0, 1, 1, 0, 0};
    exp_acc = '{0, 1, 3, 4, 7, 8};
    acc_cyc = '{-1, -1, -1, -1, -1, -1};
    idx = 0;
    nsym = 0;
    first_under = -1;
    early_under = 0;
    rst = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit_valid = (idx < 6);
      bit_in = (idx < 6) ? bits3[idx][0] : 1'b0;
      @(negedge clk);
      if (ss && nsym < 4) begin
        sym_cyc[nsym] = cyc;
        sym_i[nsym] = int'(i_s);
        sym_q[nsym] = int'(q_s);
        nsym++;
      end
      if (un) begin
        if (first_under < 0) first_under = cyc;
        if (cyc < 15) early_under++;
      end
      if (bit_valid && bit_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;

    check("bp bits accepted", idx, 6);
    for (int k = 0; k < 6; k++) check($sformatf("bp accept cycle bit%0d", k), acc_cyc[k], exp_acc[k]);
    check("bp symbol count", nsym, 3);
    if (nsym == 3) begin
      check("bp sym0 cycle", sym_cyc[0], 3);
      check("bp sym1 cycle", sym_cyc[1], 7);
      check("bp sym2 cycle", sym_cyc[2], 11);
      check("bp sym0 I", sym_i[0], P);
      check("bp sym0 Q", sym_q[0], N);
      check("bp sym1 I", sym_i[1], P);
      check("bp sym1 Q", sym_q[1], P);
      check("bp sym2 I", sym_i[2], N);
      check("bp sym2 Q", sym_q[2], N);
    end
    check("bp underrun during stream", early_under, 0);
    check("bp final underrun cycle", first_under, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
